// File: rtl/disp_sched_if.sv
// Requester/display bus of the display scheduler: four requester ports in,
// one latched display port out, plus the user controls.
interface disp_sched_if;
  logic        DISP_SWITCH;
  logic        AUTO;
  logic [3:0]  REQ;
  logic [37:0] PACKET_IN0;
  logic [37:0] PACKET_IN1;
  logic [37:0] PACKET_IN2;
  logic [37:0] PACKET_IN3;
  logic [4:0]  PC_IN0;
  logic [4:0]  PC_IN1;
  logic [4:0]  PC_IN2;
  logic [4:0]  PC_IN3;
  logic [3:0]  ACK;
  logic [37:0] PACKET_OUT;
  logic [4:0]  PC_OUT;
  logic [1:0]  SRC_ID;
  logic        VALID;
  logic        TOGLE;

  modport master (
    output DISP_SWITCH, AUTO, REQ,
    output PACKET_IN0, PACKET_IN1, PACKET_IN2, PACKET_IN3,
    output PC_IN0, PC_IN1, PC_IN2, PC_IN3,
    input  ACK, PACKET_OUT, PC_OUT, SRC_ID, VALID, TOGLE
  );

  modport slave (
    input  DISP_SWITCH, AUTO, REQ,
    input  PACKET_IN0, PACKET_IN1, PACKET_IN2, PACKET_IN3,
    input  PC_IN0, PC_IN1, PC_IN2, PC_IN3,
    output ACK, PACKET_OUT, PC_OUT, SRC_ID, VALID, TOGLE
  );
endinterface

// File: rtl/disp_sched.sv
// Round-robin display scheduler: latches one of four requester packets and
// holds it for a timed dwell (AUTO) or until the user presses the button.
module disp_sched #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input logic         CLK,
  input logic         RST,
  disp_sched_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  ptr_q;
  logic        sw_q;
  logic [3:0]  ack_q;
  logic [37:0] pkt_q;
  logic [4:0]  pc_q;
  logic [1:0]  src_q;
  logic        valid_q;
  logic        togle_q;

  logic        press;
  logic        any_req;
  logic        latch;
  logic        found;
  logic [1:0]  idx;
  logic [1:0]  win;
  logic [37:0] win_pkt;
  logic [4:0]  win_pc;

  assign press   = bus.DISP_SWITCH & ~sw_q;
  assign any_req = |bus.REQ;

  // First requesting index at or after the round-robin pointer, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_pkt = '0;
    win_pc  = '0;
    case (win)
      2'd0: begin win_pkt = bus.PACKET_IN0; win_pc = bus.PC_IN0; end
      2'd1: begin win_pkt = bus.PACKET_IN1; win_pc = bus.PC_IN1; end
      2'd2: begin win_pkt = bus.PACKET_IN2; win_pc = bus.PC_IN2; end
      default: begin win_pkt = bus.PACKET_IN3; win_pc = bus.PC_IN3; end
    endcase
  end

  // A press and dwell expiry in the same cycle share one advance decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) latch = 1'b1;
      end
      HOLD: begin
        if (press || (bus.AUTO && cnt_q == '0)) begin
          if (any_req) latch = 1'b1;
          else         state_d = IDLE;
        end else if (bus.AUTO) begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (latch) begin
      state_d = HOLD;
      cnt_d   = HOLD_LOAD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sw_q    <= 1'b0;
      ack_q   <= '0;
      pkt_q   <= '0;
      pc_q    <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      togle_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= bus.DISP_SWITCH;
      ack_q   <= '0;
      if (latch) begin
        ack_q   <= 4'b0001 << win;
        pkt_q   <= win_pkt;
        pc_q    <= win_pc;
        src_q   <= win;
        ptr_q   <= win + 2'd1;
        valid_q <= 1'b1;
        togle_q <= ~togle_q;
      end
    end
  end

  assign bus.ACK        = ack_q;
  assign bus.PACKET_OUT = pkt_q;
  assign bus.PC_OUT     = pc_q;
  assign bus.SRC_ID     = src_q;
  assign bus.VALID      = valid_q;
  assign bus.TOGLE      = togle_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched: one instance with the default dwell (16)
// and one with a short dwell (4), driven from a single stimulus thread.
module tb_disp_sched;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  disp_sched_if ia ();
  disp_sched_if ib ();

  disp_sched #(.HOLD_CYCLES(16)) u_a (.CLK(CLK), .RST(RST), .bus(ia.slave));
  disp_sched #(.HOLD_CYCLES(4))  u_b (.CLK(CLK), .RST(RST), .bus(ib.slave));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] pkt(input int i);
    return {3'(i + 1), 8'(16 + i), 7'(i), 4'b1010, 16'(120 + 100 * i)};
  endfunction

  function automatic logic [4:0] pcv(input int i);
    return 5'(3 + 5 * i);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ia.REQ = '0; ia.AUTO = 1'b0; ia.DISP_SWITCH = 1'b0;
    ib.REQ = '0; ib.AUTO = 1'b0; ib.DISP_SWITCH = 1'b0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int acks;
    int g;

    ia.PACKET_IN0 = pkt(0); ia.PACKET_IN1 = pkt(1); ia.PACKET_IN2 = pkt(2); ia.PACKET_IN3 = pkt(3);
    ib.PACKET_IN0 = pkt(0); ib.PACKET_IN1 = pkt(1); ib.PACKET_IN2 = pkt(2); ib.PACKET_IN3 = pkt(3);
    ia.PC_IN0 = pcv(0); ia.PC_IN1 = pcv(1); ia.PC_IN2 = pcv(2); ia.PC_IN3 = pcv(3);
    ib.PC_IN0 = pcv(0); ib.PC_IN1 = pcv(1); ib.PC_IN2 = pcv(2); ib.PC_IN3 = pcv(3);

    // Reset state
    do_reset();
    check("rst_ack",   64'(ia.ACK),        64'h0);
    check("rst_pkt",   64'(ia.PACKET_OUT), 64'h0);
    check("rst_pc",    64'(ia.PC_OUT),     64'h0);
    check("rst_src",   64'(ia.SRC_ID),     64'h0);
    check("rst_valid", 64'(ia.VALID),      64'h0);
    check("rst_togle", 64'(ia.TOGLE),      64'h0);

    // First grant from IDLE, one cycle after REQ
    ia.REQ = 4'b0001;
    tick();
    check("first_ack",   64'(ia.ACK),               64'h1);
    check("first_data",  64'(ia.PACKET_OUT[15:0]),  64'd120);
    check("first_pkt",   64'(ia.PACKET_OUT),        64'(pkt(0)));
    check("first_pc",    64'(ia.PC_OUT),            64'd3);
    check("first_src",   64'(ia.SRC_ID),            64'd0);
    check("first_valid", 64'(ia.VALID),             64'd1);
    check("first_togle", 64'(ia.TOGLE),             64'd1);
    tick();
    check("first_ack_pulse", 64'(ia.ACK), 64'h0);

    // Manual mode: hold forever, one advance per rising press
    do_reset();
    ia.REQ = 4'b0110;
    tick();
    check("man_src_a", 64'(ia.SRC_ID), 64'd1);
    check("man_ack_a", 64'(ia.ACK),    64'h2);
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ia.ACK != 4'b0) acks++;
    end
    check("man_hold_acks", 64'(acks), 64'd0);
    check("man_hold_src",  64'(ia.SRC_ID), 64'd1);
    ia.DISP_SWITCH = 1'b1;
    tick();
    check("man_src_b",   64'(ia.SRC_ID), 64'd2);
    check("man_ack_b",   64'(ia.ACK),    64'h4);
    check("man_togle_b", 64'(ia.TOGLE),  64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("man_held_ack", 64'(ia.ACK),    64'h0);
      check("man_held_src", 64'(ia.SRC_ID), 64'd2);
    end
    ia.DISP_SWITCH = 1'b0;
    tick();
    ia.DISP_SWITCH = 1'b1;
    tick();
    check("man_src_c",   64'(ia.SRC_ID), 64'd1);
    check("man_ack_c",   64'(ia.ACK),    64'h2);
    check("man_togle_c", 64'(ia.TOGLE),  64'd1);
    ia.DISP_SWITCH = 1'b0;
    tick();
    ia.DISP_SWITCH = 1'b1;
    tick();
    check("man_src_d", 64'(ia.SRC_ID), 64'd2);
    check("man_pc_d",  64'(ia.PC_OUT), 64'(pcv(2)));
    ia.DISP_SWITCH = 1'b0;

    // Auto rotation, dwell 4, all requesting
    do_reset();
    ib.AUTO = 1'b1;
    ib.REQ  = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if ((k - 1) % 4 == 0) begin
        g = ((k - 1) / 4) % 4;
        check("rr_ack",   64'(ib.ACK),    64'(4'b0001 << g));
        check("rr_src",   64'(ib.SRC_ID), 64'(g));
        check("rr_togle", 64'(ib.TOGLE),  64'(((k - 1) / 4 + 1) % 2));
      end else begin
        check("rr_ack_idle", 64'(ib.ACK), 64'h0);
      end
    end

    // Press mid-dwell, then press coinciding with expiry (dwell 16)
    do_reset();
    ia.AUTO = 1'b1;
    ia.REQ  = 4'b0001;
    tick();
    check("pr_first_src", 64'(ia.SRC_ID), 64'd0);
    for (int k = 0; k < 5; k++) tick();
    ia.REQ = 4'b0100;
    ia.DISP_SWITCH = 1'b1;
    tick();
    check("pr_mid_ack", 64'(ia.ACK),    64'h4);
    check("pr_mid_src", 64'(ia.SRC_ID), 64'd2);
    ia.DISP_SWITCH = 1'b0;
    acks = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ia.ACK != 4'b0) acks++;
    end
    check("pr_reload_quiet", 64'(acks), 64'd0);
    tick();
    check("pr_reload_ack", 64'(ia.ACK), 64'h4);
    acks = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ia.ACK != 4'b0) acks++;
    end
    check("pr_quiet2", 64'(acks), 64'd0);
    ia.DISP_SWITCH = 1'b1;
    ia.REQ = 4'b0101;
    tick();
    check("pr_coin_ack", 64'(ia.ACK),    64'h1);
    check("pr_coin_src", 64'(ia.SRC_ID), 64'd0);
    tick();
    check("pr_coin_single", 64'(ia.ACK),    64'h0);
    check("pr_coin_src2",   64'(ia.SRC_ID), 64'd0);
    acks = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (ia.ACK != 4'b0) acks++;
    end
    check("pr_quiet3", 64'(acks), 64'd0);
    tick();
    check("pr_next_ack", 64'(ia.ACK), 64'h4);
    ia.DISP_SWITCH = 1'b0;

    // Expiry with no requests -> IDLE, outputs retained
    do_reset();
    ib.AUTO = 1'b1;
    ib.REQ  = 4'b0001;
    tick();
    ib.REQ = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
    check("exp_ack",   64'(ib.ACK),        64'h0);
    check("exp_valid", 64'(ib.VALID),      64'd1);
    check("exp_src",   64'(ib.SRC_ID),     64'd0);
    check("exp_pkt",   64'(ib.PACKET_OUT), 64'(pkt(0)));
    check("exp_pc",    64'(ib.PC_OUT),     64'(pcv(0)));
    ib.REQ = 4'b1000;
    tick();
    check("exp_wake_ack",   64'(ib.ACK),        64'h8);
    check("exp_wake_src",   64'(ib.SRC_ID),     64'd3);
    check("exp_wake_pkt",   64'(ib.PACKET_OUT), 64'(pkt(3)));
    check("exp_wake_togle", 64'(ib.TOGLE),      64'd0);

    // Reset mid-dwell dominates REQ and press
    do_reset();
    ib.AUTO = 1'b1;
    ib.REQ  = 4'b1111;
    for (int k = 0; k < 6; k++) tick();
    check("mr_pre_src", 64'(ib.SRC_ID), 64'd1);
    RST = 1'b1;
    ib.DISP_SWITCH = 1'b1;
    tick();
    check("mr_ack",   64'(ib.ACK),        64'h0);
    check("mr_pkt",   64'(ib.PACKET_OUT), 64'h0);
    check("mr_pc",    64'(ib.PC_OUT),     64'h0);
    check("mr_src",   64'(ib.SRC_ID),     64'h0);
    check("mr_valid", 64'(ib.VALID),      64'h0);
    check("mr_togle", 64'(ib.TOGLE),      64'h0);
    RST = 1'b0;
    ib.DISP_SWITCH = 1'b0;
    tick();
    check("mr_after_ack",   64'(ib.ACK),    64'h1);
    check("mr_after_src",   64'(ib.SRC_ID), 64'd0);
    check("mr_after_togle", 64'(ib.TOGLE),  64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, meaning the auto-mode display dwell in clock cycles (legal 2..65535).
REQ-002 The block SHALL have port CLK, input, 1, system clock; all state updates on rising edge.
REQ-003 The block SHALL have port RST, input, 1, reset; one clock, synchronous, active-high.
REQ-004 The block SHALL have port DISP_SWITCH, input, 1, user advance button (level, already clean).
REQ-005 The block SHALL have port AUTO, input, 1, 1 = timed advance, 0 = advance on button only.
REQ-006 The block SHALL have port REQ, input, 4, per-requester request for display, level-held.
REQ-007 The block SHALL have ports PACKET_IN0..PACKET_IN3, input, 38 each, requester packets {3b,8b,7b,1b,1b,1b,1b,16b data}.
REQ-008 The block SHALL have ports PC_IN0..PC_IN3, input, 5 each, requester program counter.
REQ-009 The block SHALL have port ACK, output, 4, one-cycle grant pulse to the requester whose packet was latched.
REQ-010 The block SHALL have port PACKET_OUT, output, 38, latched packet driven to the display.
REQ-011 The block SHALL have port PC_OUT, output, 5, latched PC driven to the display.
REQ-012 The block SHALL have port SRC_ID, output, 2, index of requester currently displayed.
REQ-013 The block SHALL have port VALID, output, 1, high once any packet has been latched.
REQ-014 The block SHALL have port TOGLE, output, 1, inverts on every new latch.

Function
REQ-015 The block SHALL register all outputs; no combinational input-to-output path.
REQ-016 The block SHALL implement states IDLE and HOLD with a 16-bit dwell counter CNT.
REQ-017 The block SHALL detect a press as DISP_SWITCH=1 while its previous-cycle registered value was 0; one press per rising level.
REQ-018 The block SHALL select a winner round-robin: search starts at (last SRC_ID+1) mod 4, wrapping; after reset the search starts at 0.
REQ-019 A "latch event" SHALL, on one edge: load PACKET_OUT/PC_OUT from the winner, set SRC_ID=winner, ACK=one-hot(winner) for exactly that following cycle, invert TOGLE, set VALID=1, load CNT=HOLD_CYCLES-1, enter HOLD.
REQ-020 In IDLE, any REQ bit high SHALL cause a latch event on that edge (ACK visible 1 cycle after REQ first sampled).
REQ-021 In HOLD with AUTO=1, CNT SHALL decrement by 1 per cycle; at CNT=0 the block SHALL perform a latch event if any REQ is high, else go IDLE.
REQ-022 In HOLD, a press (either AUTO value) SHALL force the advance immediately: latch event if any REQ high, else IDLE.
REQ-023 In HOLD with AUTO=0, CNT SHALL hold its value and only a press advances.
REQ-024 In IDLE, PACKET_OUT, PC_OUT, SRC_ID, VALID SHALL retain last values; ACK=0.
REQ-025 Press and CNT=0 in the same cycle SHALL produce a single advance.
REQ-026 The current owner re-requesting SHALL be granted again only if no other REQ bit is high (round-robin fairness).
REQ-027 AUTO changing mid-HOLD SHALL take effect the next cycle without reloading CNT.
REQ-028 A REQ bit dropping before its ACK SHALL not be granted; selection uses REQ sampled on the latch edge.

Reset
REQ-029 On RST=1 at a clock edge the block SHALL enter IDLE with PACKET_OUT=0, PC_OUT=0, SRC_ID=0, ACK=0, VALID=0, TOGLE=0, CNT=0, RR pointer=0, press register=0, regardless of state mid-HOLD.
REQ-030 RST SHALL dominate REQ and DISP_SWITCH in the same cycle.

Verification
REQ-031 Reset then REQ=0001, PACKET_IN0 data=16'd120, PC_IN0=3 -> next cycle ACK=0001, PACKET_OUT data=120, PC_OUT=3, SRC_ID=0, VALID=1, TOGLE=1.
REQ-032 AUTO=1, HOLD_CYCLES=4, REQ=1111 held -> grants SRC_ID 0,1,2,3,0 every 4 cycles, one ACK pulse each, TOGLE toggling.
REQ-033 AUTO=0, REQ=0110 held -> SRC_ID=1 holds indefinitely; each press -> next-cycle SRC_ID alternates 2,1,2; button held high 5 cycles counts one press.
REQ-034 AUTO=1, HOLD_CYCLES=16, press at CNT=10 with REQ=0100 -> immediate latch of requester 2, CNT reloaded to 15; press coinciding with CNT=0 -> one advance only.
REQ-035 HOLD expiry with REQ=0000 -> IDLE, outputs retained; later REQ=1000 -> ACK=1000 one cycle later.
REQ-036 RST asserted mid-HOLD with REQ=1111 -> next cycle all outputs zero, IDLE; after release first grant goes to requester 0.
